multi_debounce: RTL and testbench

Parametrised N-channel push-button conditioner for the board-level input path. Each channel synchronises a raw asynchronous button, debounces it with a restart-on-bounce stability counter, and emits a clean level plus one-cycle press and release pulses. An optional auto-repeat mode emits periodic pulses while a button is held. It sits between the board pins and the checksum control logic, replacing single-channel debounce instances.

---
 rtl/multi_debounce.sv | 117 +++++++++++
 tb/tb_multi_debounce.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// ============================================================================
// Module   : multi_debounce
// Brief    : N-channel push-button conditioner. Each channel has a two-flop
//            synchroniser, a restart-on-bounce debouncer, press/release pulses
//            and optional auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debounce #(
    parameter int N             = 5,
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_repeat
);

    localparam int                 c_STB_W    = $clog2(STABLE_CYCLES);
    localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(STABLE_CYCLES - 1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_press;
        logic               r_release;
        logic [c_STB_W-1:0] r_stb_cnt;
        logic               w_mismatch;
        logic               w_accept;
        logic               w_repeat;

        assign w_mismatch = r_sync2 ^ r_level;
        assign w_accept   = w_mismatch && (r_stb_cnt == c_STB_LAST);

        // Any cycle where the synchronised input agrees with the level
        // throws away all accumulated stability credit.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_stb_cnt <= '0;
            end else begin
                r_sync1   <= btn_in[i];
                r_sync2   <= r_sync1;
                r_press   <= w_accept &  r_sync2;
                r_release <= w_accept & ~r_sync2;
                if (!w_mismatch) begin
                    r_stb_cnt <= '0;
                end else if (w_accept) begin
                    r_stb_cnt <= '0;
                    r_level   <= r_sync2;
                end else begin
                    r_stb_cnt <= r_stb_cnt + c_STB_W'(1);
                end
            end
        end

        if (REPEAT_EN != 0) begin : g_rep
            localparam int c_HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                                        HOLD_CYCLES : REPEAT_CYCLES;
            localparam int                 c_HLD_W     = $clog2(c_HOLD_MAX) + 1;
            localparam logic [c_HLD_W-1:0] c_HOLD_LAST = c_HLD_W'(HOLD_CYCLES - 1);
            localparam logic [c_HLD_W-1:0] c_REP_LAST  = c_HLD_W'(REPEAT_CYCLES - 1);

            logic [c_HLD_W-1:0] r_hold_cnt;
            logic               r_phase;
            logic               r_repeat;
            logic [c_HLD_W-1:0] w_thresh;

            assign w_thresh = r_phase ? c_REP_LAST : c_HOLD_LAST;

            // An accepted change while the level is high is a release, which
            // must win over a repeat falling on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hold_cnt <= '0;
                    r_phase    <= 1'b0;
                    r_repeat   <= 1'b0;
                end else if (!r_level || w_accept) begin
                    r_hold_cnt <= '0;
                    r_phase    <= 1'b0;
                    r_repeat   <= 1'b0;
                end else if (r_hold_cnt == w_thresh) begin
                    r_hold_cnt <= '0;
                    r_phase    <= 1'b1;
                    r_repeat   <= 1'b1;
                end else begin
                    r_hold_cnt <= r_hold_cnt + c_HLD_W'(1);
                    r_repeat   <= 1'b0;
                end
            end

            assign w_repeat = r_repeat;
        end else begin : g_norep
            assign w_repeat = 1'b0;
        end

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
        assign btn_repeat[i]  = w_repeat;
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_debounce.sv
// ============================================================================
// Module   : tb_multi_debounce
// Brief    : Directed bench for multi_debounce, repeat-enabled and
//            repeat-disabled builds driven in parallel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_debounce;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [2:0] btn_in = 3'b111;

    logic [2:0] level,  press,  rel,  rep;
    logic [2:0] level0, press0, rel0, rep0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_debounce #(
        .N(3), .STABLE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(level), .btn_press(press), .btn_release(rel), .btn_repeat(rep)
    );

    multi_debounce #(
        .N(3), .STABLE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(0)
    ) dut0 (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(level0), .btn_press(press0), .btn_release(rel0), .btn_repeat(rep0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    initial begin
        // Reset with all buttons held high
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_level", k, level, 3'b000);
            chk("rst_press", k, press, 3'b000);
            chk("rst_rel",   k, rel,   3'b000);
            chk("rst_rep",   k, rep,   3'b000);
            chk("rst_press0", k, press0, 3'b000);
        end
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("por_press",  k, press,  (k == 5) ? 3'b111 : 3'b000);
            chk("por_level",  k, level,  (k >= 5) ? 3'b111 : 3'b000);
            chk("por_press0", k, press0, (k == 5) ? 3'b111 : 3'b000);
        end

        btn_in = 3'b000;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("all_rel", k, rel, (k == 5) ? 3'b111 : 3'b000);
            chk("all_rep", k, rep, 3'b000);
        end

        // Channel 0 bounces every cycle, then settles high
        for (int k = 0; k < 18; k++) begin
            btn_in[0] = ~btn_in[0];
            tick();
            chk("bounce_press", k, press, 3'b000);
            chk("bounce_level", k, level, 3'b000);
        end
        btn_in[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("settle_press", k, press, (k == 5) ? 3'b001 : 3'b000);
        end
        chk("settle_level", 0, level, 3'b001);
        btn_in[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("ch0_rel", k, rel, (k == 5) ? 3'b001 : 3'b000);
        end

        // Channel 1: 3-cycle glitch rejected, 6-cycle pulse accepted
        for (int k = 0; k < 11; k++) begin
            btn_in[1] = (k < 3);
            tick();
            chk("glitch_level", k, level, 3'b000);
            chk("glitch_press", k, press, 3'b000);
        end
        for (int k = 0; k < 14; k++) begin
            btn_in[1] = (k < 6);
            tick();
            chk("pulse_press", k, press, (k == 5) ? 3'b010 : 3'b000);
            chk("pulse_rel",   k, rel,   (k == 11) ? 3'b010 : 3'b000);
            chk("pulse_level", k, level, (k >= 5 && k < 11) ? 3'b010 : 3'b000);
        end

        // Channel 2 held 60 cycles: repeats at P+20, then every 8
        for (int k = 0; k < 72; k++) begin
            btn_in[2] = (k < 60);
            tick();
            chk("hold_press", k, press, (k == 5) ? 3'b100 : 3'b000);
            chk("hold_rel",   k, rel,   (k == 65) ? 3'b100 : 3'b000);
            chk("hold_rep",   k, rep,
                (k == 25 || k == 33 || k == 41 || k == 49 || k == 57) ? 3'b100 : 3'b000);
            chk("hold_rep0",   k, rep0,   3'b000);
            chk("hold_press0", k, press0, (k == 5) ? 3'b100 : 3'b000);
            chk("hold_rel0",   k, rel0,   (k == 65) ? 3'b100 : 3'b000);
        end

        // Simultaneous press on 0/2 and release on 1
        btn_in = 3'b010;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("pre_press", k, press, (k == 5) ? 3'b010 : 3'b000);
        end
        btn_in = 3'b101;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("sim_press", k, press, (k == 5) ? 3'b101 : 3'b000);
            chk("sim_rel",   k, rel,   (k == 5) ? 3'b010 : 3'b000);
        end
        btn_in = 3'b000;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("sim_rel2", k, rel, (k == 5) ? 3'b101 : 3'b000);
            chk("sim_rep",  k, rep, 3'b000);
        end

        // Reset two cycles into a count discards progress
        btn_in = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_press", k, press, 3'b000);
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("mid_rst_press", k, press, 3'b000);
            chk("mid_rst_level", k, level, 3'b000);
        end
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("post_press", k, press, (k == 5) ? 3'b111 : 3'b000);
            chk("post_level", k, level, (k >= 5) ? 3'b111 : 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
